// File: rtl/ts_q_drain_pkg.sv
// rtl/ts_q_drain_pkg.sv - shared types and register map for the timestamp queue drainer
package ts_q_drain_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_POLL_RD,
    ST_POLL_WAIT,
    ST_GAP,
    ST_POP_SET,
    ST_POP_CLR,
    ST_DAT_RD,
    ST_DAT_WAIT,
    ST_EMIT
  } state_t;

  localparam logic [7:0] DEF_ADDR_STAT  = 8'h40;
  localparam logic [7:0] DEF_ADDR_CTRL  = 8'h44;
  localparam logic [7:0] DEF_ADDR_DATA0 = 8'h48;

  localparam int CTRL_POP     = 0;
  localparam int STAT_CNT_MSB = 7;
  localparam int STAT_CNT_LSB = 0;

  function automatic logic [7:0] data_addr(input logic [7:0] base, input logic [1:0] k);
    return base + {4'd0, k, 2'b00};
  endfunction

endpackage

// File: rtl/ts_q_bus_seq.sv
// rtl/ts_q_bus_seq.sv - single-access register bus sequencer with read-latency wait
module ts_q_bus_seq #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        wr,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        wr_out,
  output logic        rd_out,
  output logic [7:0]  addr_out,
  output logic [31:0] data_out,
  input  logic [31:0] data_in
);

  localparam logic [1:0] LAT = 2'(RD_LAT);

  logic       pend;
  logic [1:0] lat_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      lat_cnt <= 2'd0;
    end else if (req && !wr) begin
      pend    <= 1'b1;
      lat_cnt <= 2'd1;
    end else if (pend) begin
      if (lat_cnt == LAT) pend <= 1'b0;
      else                lat_cnt <= lat_cnt + 2'd1;
    end
  end

  // req is a one-cycle registered pulse from the caller, so strobes are one cycle wide
  assign wr_out   = req & wr;
  assign rd_out   = req & ~wr;
  assign addr_out = req ? addr : 8'd0;
  assign data_out = (req & wr) ? wdata : 32'd0;

  assign done  = (req & wr) | (pend && (lat_cnt == LAT));
  assign rdata = data_in;

endmodule

// File: rtl/ts_q_drain.sv
// rtl/ts_q_drain.sv - polls a timestamp queue over the register bus and streams 128-bit records
module ts_q_drain
  import ts_q_drain_pkg::*;
#(
  parameter logic [7:0] ADDR_STAT  = DEF_ADDR_STAT,
  parameter logic [7:0] ADDR_CTRL  = DEF_ADDR_CTRL,
  parameter logic [7:0] ADDR_DATA0 = DEF_ADDR_DATA0,
  parameter int         RD_LAT     = 1,
  parameter int         POLL_GAP   = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic         wr_out,
  output logic         rd_out,
  output logic [7:0]   addr_out,
  output logic [31:0]  data_out,
  input  logic [31:0]  data_in,
  output logic         ts_valid,
  input  logic         ts_ready,
  output logic [127:0] ts_data,
  output logic         busy,
  output logic [15:0]  rec_cnt
);

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

  state_t      state;
  logic [7:0]  gap_cnt;
  logic [1:0]  word_idx;
  logic [31:0] words [3];

  logic        acc_req;
  logic        acc_wr;
  logic [7:0]  acc_addr;
  logic [31:0] acc_wdata;
  logic        acc_done;
  logic [31:0] acc_rdata;

  ts_q_bus_seq #(.RD_LAT(RD_LAT)) u_bus_seq (
    .clk      (clk),
    .rst_n    (rst),
    .req      (acc_req),
    .wr       (acc_wr),
    .addr     (acc_addr),
    .wdata    (acc_wdata),
    .done     (acc_done),
    .rdata    (acc_rdata),
    .wr_out   (wr_out),
    .rd_out   (rd_out),
    .addr_out (addr_out),
    .data_out (data_out),
    .data_in  (data_in)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      gap_cnt   <= 8'd0;
      word_idx  <= 2'd0;
      for (int i = 0; i < 3; i++) words[i] <= 32'd0;
      acc_req   <= 1'b0;
      acc_wr    <= 1'b0;
      acc_addr  <= 8'd0;
      acc_wdata <= 32'd0;
      ts_valid  <= 1'b0;
      ts_data   <= 128'd0;
      rec_cnt   <= 16'd0;
    end else begin
      // access command is a pulse issued on the transition into each access state
      acc_req   <= 1'b0;
      acc_wr    <= 1'b0;
      acc_addr  <= 8'd0;
      acc_wdata <= 32'd0;
      case (state)
        ST_IDLE: begin
          if (en) begin
            state    <= ST_POLL_RD;
            acc_req  <= 1'b1;
            acc_addr <= ADDR_STAT;
          end
        end
        ST_POLL_RD: state <= ST_POLL_WAIT;
        ST_POLL_WAIT: begin
          if (acc_done) begin
            if (acc_rdata[STAT_CNT_MSB:STAT_CNT_LSB] != 8'd0) begin
              state     <= ST_POP_SET;
              acc_req   <= 1'b1;
              acc_wr    <= 1'b1;
              acc_addr  <= ADDR_CTRL;
              acc_wdata <= 32'd1 << CTRL_POP;
            end else if (en) begin
              state   <= ST_GAP;
              gap_cnt <= 8'd0;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (en) begin
              state    <= ST_POLL_RD;
              acc_req  <= 1'b1;
              acc_addr <= ADDR_STAT;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        ST_POP_SET: begin
          state    <= ST_POP_CLR;
          acc_req  <= 1'b1;
          acc_wr   <= 1'b1;
          acc_addr <= ADDR_CTRL;
        end
        ST_POP_CLR: begin
          state    <= ST_DAT_RD;
          word_idx <= 2'd0;
          acc_req  <= 1'b1;
          acc_addr <= data_addr(ADDR_DATA0, 2'd0);
        end
        ST_DAT_RD: state <= ST_DAT_WAIT;
        ST_DAT_WAIT: begin
          if (acc_done) begin
            if (word_idx == 2'd3) begin
              ts_data  <= {words[0], words[1], words[2], acc_rdata};
              ts_valid <= 1'b1;
              state    <= ST_EMIT;
            end else begin
              words[word_idx] <= acc_rdata;
              word_idx <= word_idx + 2'd1;
              state    <= ST_DAT_RD;
              acc_req  <= 1'b1;
              acc_addr <= data_addr(ADDR_DATA0, word_idx + 2'd1);
            end
          end
        end
        ST_EMIT: begin
          if (ts_ready) begin
            ts_valid <= 1'b0;
            rec_cnt  <= rec_cnt + 16'd1;
            if (en) begin
              state    <= ST_POLL_RD;
              acc_req  <= 1'b1;
              acc_addr <= ADDR_STAT;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = !((state == ST_IDLE) || (state == ST_GAP));

endmodule

// File: tb/tb_ts_q_drain.sv
// tb/tb_ts_q_drain.sv - scoreboard bench for ts_q_drain at RD_LAT 1 and 3
module tb_ts_q_drain;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         en [2];
  logic         ts_ready [2];
  logic         wr_out [2];
  logic         rd_out [2];
  logic [7:0]   addr_out [2];
  logic [31:0]  data_out [2];
  logic [31:0]  data_in [2];
  logic         ts_valid [2];
  logic [127:0] ts_data [2];
  logic         busy [2];
  logic [15:0]  rec_cnt [2];

  ts_q_drain #(.RD_LAT(1)) u_dut0 (
    .clk(clk), .rst(rst), .en(en[0]), .wr_out(wr_out[0]), .rd_out(rd_out[0]),
    .addr_out(addr_out[0]), .data_out(data_out[0]), .data_in(data_in[0]),
    .ts_valid(ts_valid[0]), .ts_ready(ts_ready[0]), .ts_data(ts_data[0]),
    .busy(busy[0]), .rec_cnt(rec_cnt[0])
  );

  ts_q_drain #(.RD_LAT(3)) u_dut1 (
    .clk(clk), .rst(rst), .en(en[1]), .wr_out(wr_out[1]), .rd_out(rd_out[1]),
    .addr_out(addr_out[1]), .data_out(data_out[1]), .data_in(data_in[1]),
    .ts_valid(ts_valid[1]), .ts_ready(ts_ready[1]), .ts_data(ts_data[1]),
    .busy(busy[1]), .rec_cnt(rec_cnt[1])
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] ent0[$], ent1[$], exp0[$], exp1[$];
  logic [40:0]  log0[$], log1[$];
  logic [40:0]  exp_acc [6];

  int           poll_cnt [2], stat_cyc [2], last_gap [2], wr_cnt [2], strobe_cnt [2];
  int           pop_cnt [2], dat0_cnt [2], hs_cnt [2], valid_cnt [2], lat [2], pend [2];
  logic [7:0]   pend_addr [2];
  logic [127:0] cur [2], pd [2];
  logic         pv [2], pr [2];
  logic         first_seen [2], first_wr [2];
  logic [7:0]   first_addr [2];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic int ent_size(input int i);
    return (i == 0) ? ent0.size() : ent1.size();
  endfunction
  function automatic logic [127:0] ent_pop(input int i);
    if (i == 0) return ent0.pop_front();
    return ent1.pop_front();
  endfunction
  function automatic int exp_size(input int i);
    return (i == 0) ? exp0.size() : exp1.size();
  endfunction
  function automatic logic [127:0] exp_pop(input int i);
    if (i == 0) return exp0.pop_front();
    return exp1.pop_front();
  endfunction
  function automatic void log_push(input int i, input logic [40:0] v);
    if (i == 0) log0.push_back(v);
    else        log1.push_back(v);
  endfunction
  function automatic int log_size(input int i);
    return (i == 0) ? log0.size() : log1.size();
  endfunction
  function automatic logic [40:0] log_get(input int i, input int j);
    if (i == 0) return log0[j];
    return log1[j];
  endfunction
  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Register-slave model plus stream monitor; data_in is valid only in the exact latency cycle
  task automatic slave_step(input int i);
    int k;
    int n;
    if (!rst) begin
      pend[i]    = 0;
      data_in[i] = 32'd0;
      pv[i]      = 1'b0;
      return;
    end
    data_in[i] = 32'hBAD0_BAD0;
    if (pend[i] > 0) begin
      pend[i]--;
      if (pend[i] == 0) begin
        if (pend_addr[i] == 8'h40) begin
          n = ent_size(i);
          data_in[i] = {24'h0, 8'((n > 255) ? 255 : n)};
        end else begin
          k = (int'(pend_addr[i]) - 'h48) / 4;
          if (k >= 0 && k < 4) data_in[i] = cur[i][127 - 32 * k -: 32];
        end
      end
    end
    if (wr_out[i] || rd_out[i]) begin
      strobe_cnt[i]++;
      chk("strobe_excl", wr_out[i] & rd_out[i], 0);
      if (!first_seen[i]) begin
        first_seen[i] = 1'b1;
        first_addr[i] = addr_out[i];
        first_wr[i]   = wr_out[i];
      end
    end
    if (rd_out[i]) begin
      pend[i]      = lat_of(i);
      pend_addr[i] = addr_out[i];
      if (addr_out[i] == 8'h40) begin
        if (stat_cyc[i] >= 0) last_gap[i] = cyc - stat_cyc[i];
        stat_cyc[i] = cyc;
        poll_cnt[i]++;
      end else begin
        log_push(i, {1'b0, addr_out[i], 32'h0});
        if (addr_out[i] == 8'h48) dat0_cnt[i]++;
      end
    end
    if (wr_out[i]) begin
      wr_cnt[i]++;
      log_push(i, {1'b1, addr_out[i], data_out[i]});
      if (addr_out[i] == 8'h44 && data_out[i] == 32'h1) begin
        pop_cnt[i]++;
        if (ent_size(i) > 0) cur[i] = ent_pop(i);
        else chk("pop_on_empty", 1, 0);
      end
    end
    if (ts_valid[i] && !pv[i]) begin
      valid_cnt[i]++;
      lat[i] = cyc - stat_cyc[i];
    end
    if (pv[i] && !pr[i]) begin
      chk("hold_valid", ts_valid[i], 1);
      chk("hold_data", ts_data[i], pd[i]);
    end
    if (ts_valid[i] && ts_ready[i]) begin
      hs_cnt[i]++;
      if (exp_size(i) > 0) chk($sformatf("rec%0d", i), ts_data[i], exp_pop(i));
      else chk("extra_rec", 1, 0);
    end
    pv[i] = ts_valid[i];
    pr[i] = ts_ready[i];
    pd[i] = ts_data[i];
  endtask

  always @(negedge clk) for (int i = 0; i < 2; i++) slave_step(i);

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input int i, input logic [127:0] rec, input bit expect_out);
    if (i == 0) ent0.push_back(rec); else ent1.push_back(rec);
    if (expect_out) begin
      if (i == 0) exp0.push_back(rec); else exp1.push_back(rec);
    end
  endtask

  task automatic wait_hs(input int i, input int n, input int budget);
    int c = 0;
    while (hs_cnt[i] < n && c < budget) begin tick(); c++; end
    chk($sformatf("wait_hs%0d", i), hs_cnt[i] >= n, 1);
  endtask

  task automatic chk_zero(input int i, input string tag);
    chk(tag, {wr_out[i], rd_out[i], addr_out[i], data_out[i], ts_valid[i], busy[i], rec_cnt[i]}, 0);
    chk({tag, "_data"}, ts_data[i], 0);
  endtask

  task automatic chk_log(input int i);
    chk($sformatf("log%0d_size", i), log_size(i), 6);
    for (int j = 0; j < 6; j++)
      if (j < log_size(i)) chk($sformatf("log%0d_acc%0d", i, j), log_get(i, j), exp_acc[j]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int snap;
    int c;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0; ts_ready[i] = 1'b1; data_in[i] = 32'd0;
      poll_cnt[i] = 0; stat_cyc[i] = -1; last_gap[i] = 0; wr_cnt[i] = 0; strobe_cnt[i] = 0;
      pop_cnt[i] = 0; dat0_cnt[i] = 0; hs_cnt[i] = 0; valid_cnt[i] = 0; lat[i] = 0; pend[i] = 0;
      pend_addr[i] = 8'd0; cur[i] = '0; pd[i] = '0; pv[i] = 1'b0; pr[i] = 1'b0;
      first_seen[i] = 1'b1; first_wr[i] = 1'b0; first_addr[i] = 8'd0;
    end
    exp_acc[0] = {1'b1, 8'h44, 32'h1};
    exp_acc[1] = {1'b1, 8'h44, 32'h0};
    exp_acc[2] = {1'b0, 8'h48, 32'h0};
    exp_acc[3] = {1'b0, 8'h4C, 32'h0};
    exp_acc[4] = {1'b0, 8'h50, 32'h0};
    exp_acc[5] = {1'b0, 8'h54, 32'h0};

    repeat (3) tick();
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    rst = 1'b1;
    tick();

    // empty queue: polls every 2 + POLL_GAP cycles, nothing else
    en[0] = 1'b1;
    repeat (80) tick();
    chk("poll_period", last_gap[0], 18);
    chk("poll_seen", poll_cnt[0] >= 4, 1);
    chk("empty_no_wr", wr_cnt[0], 0);
    chk("empty_no_valid", valid_cnt[0], 0);

    // single entry
    log0.delete();
    load(0, 128'h11111111_22222222_33333333_44444444, 1'b1);
    wait_hs(0, 1, 80);
    chk("lat1", lat[0], 12);
    chk("valid_1cyc", ts_valid[0], 0);
    chk("rec_cnt1", rec_cnt[0], 1);
    chk_log(0);

    // backpressure with three entries
    ts_ready[0] = 1'b0;
    load(0, 128'hA0000001_A0000002_A0000003_A0000004, 1'b1);
    load(0, 128'hB0000001_B0000002_B0000003_B0000004, 1'b1);
    load(0, 128'hC0000001_C0000002_C0000003_C0000004, 1'b1);
    c = 0;
    while (!ts_valid[0] && c < 60) begin tick(); c++; end
    chk("bp_valid_seen", ts_valid[0], 1);
    snap = strobe_cnt[0];
    repeat (20) tick();
    chk("bp_valid", ts_valid[0], 1);
    chk("bp_strobes", strobe_cnt[0] - snap, 0);
    chk("bp_rec", rec_cnt[0], 1);
    ts_ready[0] = 1'b1;
    wait_hs(0, 4, 200);
    chk("bp_rec_done", rec_cnt[0], 4);

    // en drops one cycle after POP_SET; entry still delivered, then idle
    snap = pop_cnt[0];
    load(0, 128'hD0000001_D0000002_D0000003_D0000004, 1'b1);
    c = 0;
    while (pop_cnt[0] == snap && c < 60) begin tick(); c++; end
    chk("pop_seen", pop_cnt[0] - snap, 1);
    en[0] = 1'b0;
    wait_hs(0, 5, 60);
    tick();
    chk("endrop_busy", busy[0], 0);
    chk("endrop_rec", rec_cnt[0], 5);
    snap = strobe_cnt[0];
    repeat (40) tick();
    chk("endrop_quiet", strobe_cnt[0] - snap, 0);
    chk("endrop_busy_late", busy[0], 0);

    // RD_LAT=3 instance, same entry
    log1.delete();
    load(1, 128'h11111111_22222222_33333333_44444444, 1'b1);
    en[1] = 1'b1;
    wait_hs(1, 1, 120);
    chk("lat3", lat[1], 22);
    chk("rec_cnt3", rec_cnt[1], 1);
    chk_log(1);

    // asynchronous reset while waiting on a data read
    snap = dat0_cnt[1];
    load(1, 128'hE0000001_E0000002_E0000003_E0000004, 1'b0);
    c = 0;
    while (dat0_cnt[1] == snap && c < 80) begin tick(); c++; end
    chk("dat0_seen", dat0_cnt[1] - snap, 1);
    rst = 1'b0;
    #1;
    chk_zero(0, "arst0");
    chk_zero(1, "arst1");
    tick();
    ent1.delete();
    first_seen[1] = 1'b0;
    rst = 1'b1;
    c = 0;
    while (!first_seen[1] && c < 20) begin tick(); c++; end
    chk("post_rst_seen", first_seen[1], 1);
    chk("post_rst_addr", first_addr[1], 8'h40);
    chk("post_rst_is_rd", first_wr[1], 0);

    chk("sb0_left", exp0.size(), 0);
    chk("sb1_left", exp1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
